// File: rtl/starter_sel_gen.sv
// starter_sel_gen: command-driven generator for the DUT select line.
// Commands (high length, low gap) are queued in a small FIFO and played out
// back to back on the registered sel output. done pulses once per command.
//
// state | meaning
// IDLE  | no command executing; loads the FIFO head when one is present
// HIGH  | sel high, hcnt counts remaining high cycles down to zero
// GAP   | sel low, gcnt counts remaining gap cycles down to zero
module starter_sel_gen #(
    parameter int LEN_W = 8,
    parameter int GAP_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic [GAP_W-1:0]         cmd_gap,
    input  logic                     flush,
    output logic                     sel,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] hcnt, hcnt_nxt;
    logic [GAP_W-1:0] gcnt, gcnt_nxt;
    logic [GAP_W-1:0] cur_gap, cur_gap_nxt;
    logic             sel_nxt;
    logic             done_nxt;
    logic             pop;
    logic             push;
    logic             load;
    logic             cmd_end;

    logic [LEN_W-1:0] mem_len [DEPTH];
    logic [GAP_W-1:0] mem_gap [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [LEN_W-1:0] head_len;
    logic [GAP_W-1:0] head_gap;
    logic             head_zero;

    // a flush drops any same-cycle offer, so ready is withheld during it
    assign cmd_ready = (level != LW'(DEPTH)) && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign head_len  = mem_len[rptr];
    assign head_gap  = mem_gap[rptr];
    assign head_zero = (head_len == '0) && (head_gap == '0);
    assign busy      = (state != IDLE) || (level != '0);

    // FIFO storage; contents need no reset since level guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_len[wptr] <= cmd_len;
            mem_gap[wptr] <= cmd_gap;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hcnt    <= '0;
            gcnt    <= '0;
            cur_gap <= '0;
            sel     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            hcnt    <= hcnt_nxt;
            gcnt    <= gcnt_nxt;
            cur_gap <= cur_gap_nxt;
            sel     <= sel_nxt;
            done    <= done_nxt;
        end
    end

    // next-state, counter and output decode
    always_comb begin
        state_nxt   = state;
        hcnt_nxt    = hcnt;
        gcnt_nxt    = gcnt;
        cur_gap_nxt = cur_gap;
        sel_nxt     = sel;
        done_nxt    = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        cmd_end     = 1'b0;

        case (state)
            IDLE: begin
                if (level != '0) load = 1'b1;
            end
            HIGH: begin
                if (hcnt != '0) begin
                    hcnt_nxt = hcnt - LEN_W'(1);
                end else if (cur_gap != '0) begin
                    state_nxt = GAP;
                    sel_nxt   = 1'b0;
                    gcnt_nxt  = cur_gap - GAP_W'(1);
                end else begin
                    cmd_end = 1'b1;
                end
            end
            GAP: begin
                if (gcnt != '0) gcnt_nxt = gcnt - GAP_W'(1);
                else            cmd_end  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // An empty (0,0) head is not chained onto a completion: its own done
        // would merge with the finishing command's pulse. It loads from IDLE
        // on the following edge instead, so every command yields one pulse.
        if (cmd_end) begin
            done_nxt = 1'b1;
            if (level != '0 && !head_zero) begin
                load = 1'b1;
            end else begin
                state_nxt = IDLE;
                sel_nxt   = 1'b0;
            end
        end

        if (load) begin
            pop         = 1'b1;
            cur_gap_nxt = head_gap;
            if (head_len != '0) begin
                state_nxt = HIGH;
                sel_nxt   = 1'b1;
                hcnt_nxt  = head_len - LEN_W'(1);
            end else if (head_gap != '0) begin
                state_nxt = GAP;
                sel_nxt   = 1'b0;
                gcnt_nxt  = head_gap - GAP_W'(1);
            end else begin
                state_nxt = IDLE;
                sel_nxt   = 1'b0;
                done_nxt  = 1'b1;
            end
        end

        if (flush) begin
            state_nxt = IDLE;
            sel_nxt   = 1'b0;
            done_nxt  = 1'b0;
            hcnt_nxt  = '0;
            gcnt_nxt  = '0;
            pop       = 1'b0;
        end
    end

endmodule

// File: tb/tb_starter_sel_gen.sv
// Testbench for starter_sel_gen: directed scenarios followed by random traffic,
// all compared cycle by cycle against a remaining-cycles reference model.
module tb_starter_sel_gen;

    localparam int LEN_W = 8;
    localparam int GAP_W = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [GAP_W-1:0] cmd_gap;
    logic             flush;
    logic             sel;
    logic             busy;
    logic             done;
    logic [2:0]       level;

    int checks   = 0;
    int failures = 0;

    // model: queued commands plus remaining high/low cycles of the active one
    int q_len[$];
    int q_gap[$];
    bit m_active;
    int m_hi;
    int m_lo;
    bit m_done;

    int sel_hi_cnt;
    int done_cnt;

    starter_sel_gen #(.LEN_W(LEN_W), .GAP_W(GAP_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_gap   (cmd_gap),
        .flush     (flush),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_len.delete();
        q_gap.delete();
        m_active = 0;
        m_hi = 0;
        m_lo = 0;
        m_done = 0;
    endtask

    task automatic model_step(input bit v, input int l, input int g, input bit f);
        bit rdy;
        bit completed;
        rdy = (q_len.size() < DEPTH) && !f;
        m_done = 0;
        if (f) begin
            model_reset();
            return;
        end
        completed = 0;
        if (m_active) begin
            if (m_hi > 0) m_hi--;
            else          m_lo--;
            if (m_hi == 0 && m_lo == 0) begin
                completed = 1;
                m_active = 0;
                m_done = 1;
            end
        end
        if (!m_active && q_len.size() > 0) begin
            if (!(completed && q_len[0] == 0 && q_gap[0] == 0)) begin
                if (q_len[0] == 0 && q_gap[0] == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1;
                    m_hi = q_len[0];
                    m_lo = q_gap[0];
                end
                void'(q_len.pop_front());
                void'(q_gap.pop_front());
            end
        end
        if (v && rdy) begin
            q_len.push_back(l);
            q_gap.push_back(g);
        end
    endtask

    // one clock: drive inputs, check ready mid-cycle, then check outputs after the edge
    task automatic step(input bit v, input int l, input int g, input bit f);
        bit exp_rdy;
        cmd_valid = v;
        cmd_len   = LEN_W'(l);
        cmd_gap   = GAP_W'(g);
        flush     = f;
        exp_rdy   = (q_len.size() < DEPTH) && !f;
        @(negedge clk);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
        @(posedge clk);
        model_step(v, l, g, f);
        #1;
        chk("sel",   32'(sel),   32'(m_active && m_hi > 0));
        chk("done",  32'(done),  32'(m_done));
        chk("busy",  32'(busy),  32'(m_active || q_len.size() > 0));
        chk("level", 32'(level), 32'(q_len.size()));
        if (sel === 1'b1)  sel_hi_cnt++;
        if (done === 1'b1) done_cnt++;
        cmd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!m_active && q_len.size() == 0) break;
            step(0, 0, 0, 0);
        end
        step(0, 0, 0, 0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic clear_counts();
        sel_hi_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        int accepted;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        cmd_gap = '0;
        flush = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",   32'(sel),   32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // scenario 1: (3,2) -> sel high 3 cycles, low 2, one done
        clear_counts();
        step(1, 3, 2, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        chk("s1_sel_hi", 32'(sel_hi_cnt), 32'd3);
        chk("s1_done",   32'(done_cnt),   32'd1);

        // scenario 2: (2,0) then (3,0) -> 5 continuous high cycles, two dones
        clear_counts();
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        drain(20);
        chk("s2_sel_hi", 32'(sel_hi_cnt), 32'd5);
        chk("s2_done",   32'(done_cnt),   32'd2);

        // scenario 3: hold valid for 8 pushes of (5,5) against a 4-entry FIFO
        clear_counts();
        accepted = 0;
        for (int i = 0; i < 200 && accepted < 8; i++) begin
            if (q_len.size() < DEPTH) accepted++;
            step(1, 5, 5, 0);
        end
        chk("s3_accepted", 32'(accepted), 32'd8);
        drain(200);
        chk("s3_sel_hi", 32'(sel_hi_cnt), 32'd40);
        chk("s3_done",   32'(done_cnt),   32'd8);

        // scenario 4: (0,3) then (0,0) -> no sel, two dones on adjacent cycles
        clear_counts();
        step(1, 0, 3, 0);
        step(1, 0, 0, 0);
        drain(20);
        chk("s4_sel_hi", 32'(sel_hi_cnt), 32'd0);
        chk("s4_done",   32'(done_cnt),   32'd2);

        // scenario 5: three (4,4), flush during the second high cycle
        clear_counts();
        step(1, 4, 4, 0);
        step(1, 4, 4, 0);
        step(1, 4, 4, 0);
        step(1, 4, 4, 1);
        chk("s5_sel",   32'(sel),   32'd0);
        chk("s5_level", 32'(level), 32'd0);
        chk("s5_busy",  32'(busy),  32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk("s5_done", 32'(done_cnt), 32'd0);

        // scenario 6: asynchronous reset mid-HIGH
        step(1, 4, 0, 0);
        step(1, 2, 2, 0);
        step(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_sel",   32'(sel),   32'd0);
        chk("s6_async_level", 32'(level), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("s6_ready", 32'(cmd_ready), 32'd1);
        chk("s6_busy",  32'(busy),      32'd0);
        clear_counts();
        step(1, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("s6_sel_hi", 32'(sel_hi_cnt), 32'd1);
        chk("s6_done",   32'(done_cnt),   32'd1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 5),
                 $urandom_range(0, 4), $urandom_range(0, 39) == 0);
        end
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
